fp16_mac_ctrl: RTL and testbench

- Sequencing controller for the non-pipelined FP16 MAC datapath (operand registers, exponent add/bias path, mantissa multiplier, normalizer, accumulator).
- Runs a dot-product job of `len` operand pairs. For each pair it gates the operand handshake and drives the stage enables in order. It collects the overflow and underflow indications from the exponent path into sticky flags.
- Operand data goes straight to the datapath. This block carries control only.

---
 rtl/fp16_mac_ctrl_if.sv | 35 +++
 rtl/fp16_mac_ctrl.sv | 143 ++++++++++++++
 tb/tb_fp16_mac_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fp16_mac_ctrl_if.sv
// Control bundle between the FP16 MAC sequencer, its job host and the MAC datapath.
// The master side is the sequencer; the slave side is the host plus datapath.
interface fp16_mac_ctrl_if #(
    parameter int CNT_W = 5
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             abort;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic             op_load;
    logic             mul_en;
    logic             norm_en;
    logic             acc_en;
    logic             acc_clr;
    logic             dp_ovf;
    logic             dp_unf;
    logic             done;
    logic             ovf_flag;
    logic             unf_flag;
    logic [CNT_W-1:0] elem_cnt;

    modport master (
        input  start, len, abort, in_valid, dp_ovf, dp_unf,
        output busy, in_ready, op_load, mul_en, norm_en, acc_en, acc_clr,
               done, ovf_flag, unf_flag, elem_cnt
    );

    modport slave (
        output start, len, abort, in_valid, dp_ovf, dp_unf,
        input  busy, in_ready, op_load, mul_en, norm_en, acc_en, acc_clr,
               done, ovf_flag, unf_flag, elem_cnt
    );
endinterface

// File: rtl/fp16_mac_ctrl.sv
// Sequencing controller for the non-pipelined FP16 MAC datapath: runs a dot-product
// job of len operand pairs, driving stage enables in order and collecting sticky flags.
module fp16_mac_ctrl #(
    parameter int MAX_LEN = 16,
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 5
) (
    input  logic            clk,
    input  logic            rst,
    fp16_mac_ctrl_if.master mac
);
    localparam int               MC_W     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] MAX_Q    = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [MC_W-1:0]  MUL_LOAD = MC_W'(MUL_LAT - 1);
    localparam logic [MC_W-1:0]  MC_ONE   = MC_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_OP,
        MUL,
        NORM,
        ACC,
        DONE
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] elem_cnt_q;
    logic [MC_W-1:0]  mul_cnt;
    logic             busy_q;
    logic             rdy_q;
    logic             mul_en_q;
    logic             norm_en_q;
    logic             acc_en_q;
    logic             acc_clr_q;
    logic             done_q;
    logic             ovf_q;
    logic             unf_q;
    logic [CNT_W-1:0] len_clamped;

    assign len_clamped = (mac.len > MAX_Q) ? MAX_Q : mac.len;

    // abort outranks every transition; in IDLE it also masks a simultaneous start
    always_comb begin
        nxt = state;
        if (mac.abort) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (mac.start) nxt = CLEAR;
                CLEAR:   nxt = (len_q == '0) ? DONE : WAIT_OP;
                WAIT_OP: if (mac.in_valid) nxt = MUL;
                MUL:     if (mul_cnt == '0) nxt = NORM;
                NORM:    nxt = ACC;
                ACC:     nxt = ((elem_cnt_q + CNT_ONE) == len_q) ? DONE : WAIT_OP;
                DONE:    nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    // Stage enables are decoded from the next state so they are registered
    // yet still line up with the cycle the FSM occupies that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            len_q      <= '0;
            elem_cnt_q <= '0;
            mul_cnt    <= '0;
            busy_q     <= 1'b0;
            rdy_q      <= 1'b0;
            mul_en_q   <= 1'b0;
            norm_en_q  <= 1'b0;
            acc_en_q   <= 1'b0;
            acc_clr_q  <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state     <= nxt;
            busy_q    <= (nxt != IDLE);
            rdy_q     <= (nxt == WAIT_OP);
            mul_en_q  <= (nxt == MUL);
            norm_en_q <= (nxt == NORM);
            acc_en_q  <= (nxt == ACC);
            acc_clr_q <= (nxt == CLEAR);
            done_q    <= (nxt == DONE);

            if (state == WAIT_OP && mac.in_valid) begin
                mul_cnt <= MUL_LOAD;
            end else if (state == MUL && mul_cnt != '0) begin
                mul_cnt <= mul_cnt - MC_ONE;
            end

            if (mac.abort) begin
                if (state != IDLE) begin
                    elem_cnt_q <= '0;
                    ovf_q      <= 1'b0;
                    unf_q      <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (mac.start) begin
                            len_q      <= len_clamped;
                            elem_cnt_q <= '0;
                            ovf_q      <= 1'b0;
                            unf_q      <= 1'b0;
                        end
                    end
                    NORM: begin
                        ovf_q <= ovf_q | mac.dp_ovf;
                        unf_q <= unf_q | mac.dp_unf;
                    end
                    ACC: begin
                        elem_cnt_q <= elem_cnt_q + CNT_ONE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign mac.busy     = busy_q;
    assign mac.in_ready = rdy_q;
    assign mac.op_load  = rdy_q & mac.in_valid;
    assign mac.mul_en   = mul_en_q;
    assign mac.norm_en  = norm_en_q;
    assign mac.acc_en   = acc_en_q;
    assign mac.acc_clr  = acc_clr_q;
    assign mac.done     = done_q;
    assign mac.ovf_flag = ovf_q;
    assign mac.unf_flag = unf_q;
    assign mac.elem_cnt = elem_cnt_q;

    a_one_stage: assert property (@(posedge clk) disable iff (rst)
        $onehot0({mac.op_load, mul_en_q, norm_en_q, acc_en_q, acc_clr_q}));

endmodule

// File: tb/tb_fp16_mac_ctrl.sv
// Bench for fp16_mac_ctrl: each job's expected per-cycle outputs come from an
// arithmetic schedule of handshake, multiply, normalize and accumulate slots.
module tb_fp16_mac_ctrl;
    localparam int MAX_LEN = 16;
    localparam int MUL_LAT = 2;
    localparam int CNT_W   = 5;
    localparam int MAXC    = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    bit vld [MAXC];
    bit dpo [MAXC];
    bit dpu [MAXC];
    bit e_rdy [MAXC];
    bit e_mul [MAXC];
    bit e_norm [MAXC];
    bit e_acc [MAXC];

    fp16_mac_ctrl_if #(.CNT_W(CNT_W)) mac_bus ();

    fp16_mac_ctrl #(
        .MAX_LEN(MAX_LEN),
        .MUL_LAT(MUL_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mac(mac_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {busy, in_ready, op_load, mul_en, norm_en, acc_en, acc_clr, done}
    function automatic logic [7:0] obs_vec();
        return {mac_bus.busy, mac_bus.in_ready, mac_bus.op_load, mac_bus.mul_en,
                mac_bus.norm_en, mac_bus.acc_en, mac_bus.acc_clr, mac_bus.done};
    endfunction

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mac_bus.start    = 1'b0;
        mac_bus.len      = '0;
        mac_bus.abort    = 1'b0;
        mac_bus.in_valid = 1'b0;
        mac_bus.dp_ovf   = 1'b0;
        mac_bus.dp_unf   = 1'b0;
    endtask

    // vmode: 0 valid always, 1 valid low in cycles 7..10, 2 random stalls
    // abort_in: -1 none, -2 random busy cycle, else that cycle
    // dpmode: 0 random flags, 1 ovf only in element 2 NORM and unf in every MUL cycle
    task automatic run_job(input int len_in, input int vmode, input int abort_in,
                           input int dpmode, input int rst_cyc);
        int n, t, done_c, idle_c, ab, cnt_e, prev;
        int ld [16];
        int nm [16];
        int ac [16];
        bit aborted, live, busy_e, ovf_e, unf_e;
        logic [7:0] ev;

        n = (len_in > MAX_LEN) ? MAX_LEN : len_in;
        for (int c = 0; c < MAXC; c++) begin
            case (vmode)
                0:       vld[c] = 1'b1;
                1:       vld[c] = !(c >= 7 && c <= 10);
                default: vld[c] = ($urandom_range(99) >= 30);
            endcase
            e_rdy[c] = 1'b0; e_mul[c] = 1'b0; e_norm[c] = 1'b0; e_acc[c] = 1'b0;
        end

        t = 2;
        for (int k = 0; k < n; k++) begin
            prev = t;
            while (!vld[t] && t < MAXC - 20) t++;
            ld[k] = t;
            nm[k] = t + MUL_LAT + 1;
            ac[k] = t + MUL_LAT + 2;
            for (int c = prev; c <= ld[k]; c++) e_rdy[c] = 1'b1;
            for (int m = 1; m <= MUL_LAT; m++) e_mul[ld[k] + m] = 1'b1;
            e_norm[nm[k]] = 1'b1;
            e_acc[ac[k]]  = 1'b1;
            t = ac[k] + 1;
        end
        done_c = t;

        for (int c = 0; c < MAXC; c++) begin
            if (dpmode == 1) begin
                dpo[c] = (n > 1) && (c == nm[1]);
                dpu[c] = e_mul[c];
            end else begin
                dpo[c] = ($urandom_range(3) == 0);
                dpu[c] = ($urandom_range(3) == 0);
            end
        end

        ab = abort_in;
        if (ab == -2) ab = $urandom_range(done_c - 1, 1);
        aborted = (ab >= 0) && (ab < done_c);
        idle_c  = aborted ? ab + 1 : done_c + 1;

        for (int c = 0; c <= idle_c; c++) begin
            @(posedge clk);
            #1;
            mac_bus.start    = (c == 0) || (c < idle_c && $urandom_range(4) == 0);
            mac_bus.len      = (c == 0) ? CNT_W'(len_in) : CNT_W'($urandom);
            mac_bus.abort    = (c == ab);
            mac_bus.in_valid = vld[c];
            mac_bus.dp_ovf   = dpo[c];
            mac_bus.dp_unf   = dpu[c];
            @(negedge clk);

            live   = !(aborted && c > ab);
            busy_e = (c >= 1) && (c < idle_c);
            ev = {busy_e, live & e_rdy[c], live & e_rdy[c] & vld[c], live & e_mul[c],
                  live & e_norm[c], live & e_acc[c], (c == 1), live & (c == done_c)};
            chk("ctrl_vec", c, 32'(obs_vec()), 32'(ev));

            if (c >= 2) begin
                cnt_e = 0; ovf_e = 1'b0; unf_e = 1'b0;
                if (live) begin
                    for (int k = 0; k < n; k++) begin
                        if (ac[k] < c) cnt_e++;
                        if (nm[k] < c) begin
                            ovf_e |= dpo[nm[k]];
                            unf_e |= dpu[nm[k]];
                        end
                    end
                end
                chk("elem_cnt", c, 32'(mac_bus.elem_cnt), 32'(cnt_e));
                chk("flags", c, 32'({mac_bus.ovf_flag, mac_bus.unf_flag}), 32'({ovf_e, unf_e}));
            end

            if (c == rst_cyc) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_async_vec", c, 32'(obs_vec()), 32'h0);
                chk("rst_async_cnt", c, 32'(mac_bus.elem_cnt), 32'h0);
                chk("rst_async_flags", c, 32'({mac_bus.ovf_flag, mac_bus.unf_flag}), 32'h0);
                idle_inputs();
                return;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        #2;
        chk("reset_vec", 0, 32'(obs_vec()), 32'h0);
        chk("reset_cnt", 0, 32'({mac_bus.elem_cnt, mac_bus.ovf_flag, mac_bus.unf_flag}), 32'h0);
        #10 rst = 1'b0;

        run_job(3, 0, -1, 0, -1);   // back-to-back operands
        run_job(3, 1, -1, 0, -1);   // in_valid low in cycles 7..10
        run_job(0, 0, -1, 0, -1);   // empty job
        run_job(20, 2, -1, 0, -1);  // clamped to MAX_LEN with random stalls
        run_job(3, 0, -1, 1, -1);   // overflow only in element 2 NORM
        run_job(3, 0, -1, 0, -1);   // new job starts with cleared flags
        run_job(3, 0, 8, 0, -1);    // abort in element 2 first MUL cycle

        @(posedge clk);
        #1;
        mac_bus.start = 1'b1;
        mac_bus.abort = 1'b1;
        mac_bus.len   = CNT_W'(3);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        chk("abort_start_idle", 0, 32'(obs_vec()), 32'h0);

        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(20, 0), 2, ($urandom_range(1) == 1) ? -2 : -1, 0, -1);
        end

        run_job(3, 0, -1, 0, 5);    // asynchronous reset inside NORM
        @(posedge clk);
        #1;
        chk("rst_held_vec", 0, 32'(obs_vec()), 32'h0);
        rst = 1'b0;
        run_job(1, 0, -1, 0, -1);   // single pair completes with done in cycle 7

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
